countdown_timer: RTL
====================

// Module: countdown_timer
// PURPOSE
//  Count-down H:M:S timer, the decrementing counterpart of the stopwatch mode.
//  The user loads a duration with set buttons, then starts, pauses or clears it.
//  The timer counts down to 00:00:00 and then raises an alarm.
//  It sits beside the clock/stopwatch blocks; the display mux selects data_t when rezhim==MODE_ID.
// PARAMETERS
//  CLK_DIV     50000000  clock cycles per 1 s tick (>=2)
//  MODE_ID     3         rezhim value in which buttons are honoured
//  ALARM_SECS  10        alarm duration in ticks before auto-dismiss (>=1)
// PORTS
//  clock              in   1   system clock, all logic on posedge
//  reset              in   1   synchronous, active-high
//  rezhim             in   2   current UI mode
//  button_start_stop  in   1   1-cycle pulse: start / pause / resume / dismiss
//  button_reset       in   1   1-cycle pulse: clear to 00:00:00, go IDLE
//  button_set_hour    in   1   1-cycle pulse: hour+1 (IDLE only)
//  button_set_min     in   1   1-cycle pulse: min+1 (IDLE only)
//  data_t             out  24  [23:16] hour 0-23, [15:8] min 0-59, [7:0] sec 0-59, binary
//  running            out  1   1 in RUN
//  alarm              out  1   1 in ALARM
// BEHAVIOUR
//  Reset: state=IDLE, data_t=0, prescaler=0, alarm counter=0, running=0, alarm=0.
//  btn_ok = (rezhim==MODE_ID). A button is ignored when btn_ok=0.
//  Counting and alarm timeout continue in any mode.
//  tick = (prescaler==CLK_DIV-1) in RUN or ALARM.
//   On tick the prescaler wraps to 0; otherwise it increments.
//   In PAUSE the prescaler holds. On IDLE->RUN the prescaler is cleared.
//  Priority per cycle: button_reset > button_start_stop > set buttons.
//   set_hour and set_min in the same cycle are both applied.
//  States:
//   IDLE:  set_hour: hour = (hour==23)?0:hour+1. set_min: min = (min==59)?0:min+1.
//          No carry; sec is unchanged by set buttons.
//          start with data_t!=0 -> RUN. start with data_t==0 is ignored (stay IDLE).
//   RUN:   on tick, decrement with borrow:
//           sec>0: sec-1.
//           else sec=59 and min-1; if min==0, min=59 and hour-1.
//          Tick while data_t==00:00:01: data_t<=0 and state<=ALARM on the same edge,
//          so alarm=1 the following cycle.
//          start -> PAUSE. reset -> IDLE with data_t=0.
//          start and tick in the same cycle: the decrement is applied, then PAUSE.
//   PAUSE: data_t held. start -> RUN, prescaler resumes from its held value.
//          reset -> IDLE with data_t=0. Set buttons ignored.
//   ALARM: data_t=0. The alarm counter clears on entry and increments per tick.
//          When the count reaches ALARM_SECS -> IDLE.
//          start or reset (btn_ok) -> IDLE immediately. Set buttons ignored.
//  Outputs are registered. running and alarm are decoded from the state register,
//  with no extra latency vs state.
//  data_t never holds an illegal value (sec/min > 59, hour > 23).
//  Reset asserted in any state overrides all inputs the same cycle.
// TESTING  (CLK_DIV=4, ALARM_SECS=3, MODE_ID=3, rezhim=3 unless noted)
//  1 Reset, then set_min x2, set_hour x1, start -> data_t 01:02:00.
//    4 clocks later 01:01:59; running=1.
//  2 Load 00:00:02, start -> 00:00:01 after 4 clks, 00:00:00 after 8 clks with alarm=1 next cycle.
//    alarm drops after 3 ticks (12 clks); state IDLE.
//  3 RUN at 00:01:00, start on the tick cycle -> 00:00:59 then PAUSE.
//    Hold 20 clks: no change. start -> resumes, next decrement after the remaining prescaler cycles.
//  4 Set buttons and start with rezhim=0 -> ignored.
//    While RUN, switch rezhim=1 -> counting continues; start pulse ignored.
//  5 IDLE at 00:00:00, start -> stays IDLE, running=0.
//    set_min at 59 -> min 0, hour unchanged. set_hour at 23 -> 0.
//  6 RUN, pulse reset and start together -> IDLE, data_t=0.
//    Reset mid-ALARM -> all outputs 0 next cycle.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Countdown timer UI bus: mode select, button pulses and display/status outputs.
interface countdown_timer_if;
  logic [1:0]  rezhim;
  logic        button_start_stop;
  logic        button_reset;
  logic        button_set_hour;
  logic        button_set_min;
  logic [23:0] data_t;
  logic        running;
  logic        alarm;

  modport master (
    output rezhim, button_start_stop, button_reset, button_set_hour, button_set_min,
    input  data_t, running, alarm
  );

  modport slave (
    input  rezhim, button_start_stop, button_reset, button_set_hour, button_set_min,
    output data_t, running, alarm
  );
endinterface

// File: rtl/countdown_timer.sv
// Count-down H:M:S timer with alarm. Buttons are honoured only when rezhim
// equals MODE_ID; counting and alarm timeout run in every mode.
module countdown_timer #(
  parameter int unsigned CLK_DIV    = 50000000,
  parameter int unsigned MODE_ID    = 3,
  parameter int unsigned ALARM_SECS = 10
) (
  input logic              clock,
  input logic              reset,
  countdown_timer_if.slave tmr
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned AW = $clog2(ALARM_SECS + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  state_t        state, state_n;
  logic [7:0]    hr, mn, sc;
  logic [7:0]    hr_n, mn_n, sc_n;
  logic [PW-1:0] presc, presc_n;
  logic [AW-1:0] acnt, acnt_n;

  logic btn_ok, b_start, b_reset, b_hour, b_min;
  logic tick, is_zero, at_one;

  assign btn_ok  = (tmr.rezhim == 2'(MODE_ID));
  assign b_start = btn_ok & tmr.button_start_stop;
  assign b_reset = btn_ok & tmr.button_reset;
  assign b_hour  = btn_ok & tmr.button_set_hour;
  assign b_min   = btn_ok & tmr.button_set_min;

  assign tick    = ((state == RUN) || (state == ALARM)) && (presc == PW'(CLK_DIV - 1));
  assign is_zero = (hr == 8'd0) && (mn == 8'd0) && (sc == 8'd0);
  assign at_one  = (hr == 8'd0) && (mn == 8'd0) && (sc <= 8'd1);

  assign tmr.data_t  = {hr, mn, sc};
  assign tmr.running = (state == RUN);
  assign tmr.alarm   = (state == ALARM);

  // State, time value, prescaler and alarm counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      hr    <= '0;
      mn    <= '0;
      sc    <= '0;
      presc <= '0;
      acnt  <= '0;
    end else begin
      state <= state_n;
      hr    <= hr_n;
      mn    <= mn_n;
      sc    <= sc_n;
      presc <= presc_n;
      acnt  <= acnt_n;
    end
  end

  // Next-state, time update and button handling with reset > start > set priority
  always_comb begin
    state_n = state;
    hr_n    = hr;
    mn_n    = mn;
    sc_n    = sc;
    presc_n = presc;
    acnt_n  = acnt;

    unique case (state)
      IDLE: begin
        // Prescaler parked at zero so every RUN starts with a full second.
        presc_n = '0;
        acnt_n  = '0;
        if (b_reset) begin
          hr_n = '0;
          mn_n = '0;
          sc_n = '0;
        end else if (b_start) begin
          if (!is_zero) state_n = RUN;
        end else begin
          if (b_hour) hr_n = (hr == 8'd23) ? 8'd0 : hr + 8'd1;
          if (b_min)  mn_n = (mn == 8'd59) ? 8'd0 : mn + 8'd1;
        end
      end

      RUN: begin
        presc_n = tick ? '0 : presc + PW'(1);
        if (b_reset) begin
          state_n = IDLE;
          hr_n    = '0;
          mn_n    = '0;
          sc_n    = '0;
        end else begin
          if (tick) begin
            if (at_one) begin
              hr_n    = '0;
              mn_n    = '0;
              sc_n    = '0;
              state_n = ALARM;
              acnt_n  = '0;
            end else if (sc != 8'd0) begin
              sc_n = sc - 8'd1;
            end else begin
              sc_n = 8'd59;
              if (mn != 8'd0) begin
                mn_n = mn - 8'd1;
              end else begin
                mn_n = 8'd59;
                hr_n = hr - 8'd1;
              end
            end
          end
          // Reaching zero wins over a simultaneous pause so the alarm is never lost.
          if (b_start && !(tick && at_one)) state_n = PAUSE;
        end
      end

      PAUSE: begin
        if (b_reset) begin
          state_n = IDLE;
          hr_n    = '0;
          mn_n    = '0;
          sc_n    = '0;
        end else if (b_start) begin
          state_n = RUN;
        end
      end

      ALARM: begin
        presc_n = tick ? '0 : presc + PW'(1);
        hr_n    = '0;
        mn_n    = '0;
        sc_n    = '0;
        if (b_reset || b_start) begin
          state_n = IDLE;
        end else if (tick) begin
          if (acnt == AW'(ALARM_SECS - 1)) begin
            state_n = IDLE;
            acnt_n  = '0;
          end else begin
            acnt_n = acnt + AW'(1);
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
